// File: rtl/upsample2x_stream_pkg.sv
// Shared definitions for the 2x stream upsampler: FSM state encodings and rounding constants.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package upsample2x_stream_pkg;

  // Frame sequencing states. Plain 4-bit constants keep older tools happy.
  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_LOAD_TOP  = 4'd1;
  localparam logic [3:0] ST_LOAD_BOT  = 4'd2;
  localparam logic [3:0] ST_EMIT_EVEN = 4'd3;
  localparam logic [3:0] ST_EMIT_ODD  = 4'd4;
  localparam logic [3:0] ST_SHIFT     = 4'd5;
  localparam logic [3:0] ST_LAST_EVEN = 4'd6;
  localparam logic [3:0] ST_LAST_ODD  = 4'd7;
  localparam logic [3:0] ST_DONE      = 4'd8;

  // Round-half-up offsets for a two-tap (>>1) and a four-tap (>>2) average.
  localparam int RND_PAIR = 1;
  localparam int RND_QUAD = 2;

  // States in which the block takes input pixels.
  function automatic logic is_load_state(input logic [3:0] st);
    return (st == ST_IDLE) || (st == ST_LOAD_TOP) || (st == ST_LOAD_BOT);
  endfunction

  // States in which the block presents output pixels.
  function automatic logic is_emit_state(input logic [3:0] st);
    return (st == ST_EMIT_EVEN) || (st == ST_EMIT_ODD) ||
           (st == ST_LAST_EVEN) || (st == ST_LAST_ODD);
  endfunction

  // Odd output rows sit between two input rows (vertical tap a=1).
  function automatic logic is_odd_row_state(input logic [3:0] st);
    return (st == ST_EMIT_ODD) || (st == ST_LAST_ODD);
  endfunction

endpackage

// File: rtl/upsample2x_stream_interp2x.sv
// One channel of the 2x interpolator: picks p00, a two-tap or a four-tap rounded average.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller holds the taps stable while the beat is stalled.
module upsample_interp2x
  import upsample2x_stream_pkg::*;
#(
  parameter int LENGTH = 12
) (
  input  logic [LENGTH-1:0] p00,
  input  logic [LENGTH-1:0] p01,
  input  logic [LENGTH-1:0] p10,
  input  logic [LENGTH-1:0] p11,
  input  logic              a,
  input  logic              b,
  input  logic              nearest,
  output logic [LENGTH-1:0] q
);

  // Two guard bits cover the worst-case four-tap sum plus rounding offset.
  localparam int SW = LENGTH + 2;

  logic [SW-1:0] sum_h;
  logic [SW-1:0] sum_v;
  logic [SW-1:0] sum_q;

  // Sums for the horizontal, vertical and diagonal phases, each with its rounding offset.
  always_comb begin
    sum_h = SW'(p00) + SW'(p01) + SW'(RND_PAIR);
    sum_v = SW'(p00) + SW'(p10) + SW'(RND_PAIR);
    sum_q = SW'(p00) + SW'(p01) + SW'(p10) + SW'(p11) + SW'(RND_QUAD);
  end

  // Phase select; nearest mode and the (0,0) phase both pass the anchor pixel through.
  always_comb begin
    q = p00;
    if (!nearest) begin
      case ({a, b})
        2'b01:   q = LENGTH'(sum_h >> 1);
        2'b10:   q = LENGTH'(sum_v >> 1);
        2'b11:   q = LENGTH'(sum_q >> 2);
        default: q = p00;
      endcase
    end
  end

endmodule

// File: rtl/upsample2x_stream.sv
// 2x image upsampler on a valid/ready pixel stream, bilinear or nearest, two line buffers.
// Latency: first output beat one cycle after the second input row completes.
// Backpressure: input stalls while emitting; output holds beat and column while m_ready=0.
module upsample2x_stream
  import upsample2x_stream_pkg::*;
#(
  parameter int IMG_W  = 4,
  parameter int IMG_H  = 4,
  parameter int LENGTH = 12,
  parameter int FRAC   = 8,
  parameter int CH     = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [CH*LENGTH-1:0] s_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [CH*LENGTH-1:0] m_data,
  output logic                m_eol,
  output logic                m_last,
  output logic                done,
  output logic                busy
);

  localparam int DW = CH * LENGTH;
  // Column counter spans output columns 0..2*IMG_W-1; input columns reuse its low bits.
  localparam int CW = $clog2(2 * IMG_W);
  localparam int XW = CW - 1;
  // Row-pair counter only needs to reach IMG_H-2.
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H - 1) : 1;

  logic [3:0]    state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          mode_q;

  logic [DW-1:0] top_buf [IMG_W];
  logic [DW-1:0] bot_buf [IMG_W];

  logic          s_fire;
  logic          m_fire;
  logic          in_last_col;
  logic          out_last_col;
  logic          row_last;
  logic          odd_row;
  logic          copy_down;
  logic [XW-1:0] wr_idx;
  logic [XW-1:0] tap_c;
  logic [XW-1:0] tap_cn;
  logic [DW-1:0] t0;
  logic [DW-1:0] t1;
  logic [DW-1:0] b0;
  logic [DW-1:0] b1;

  // Handshake outputs are forced low while reset is held, independent of state.
  always_comb begin
    s_ready = !rst && is_load_state(state);
    m_valid = !rst && is_emit_state(state);
    m_eol   = m_valid && out_last_col;
    m_last  = m_valid && (state == ST_LAST_ODD) && out_last_col;
    done    = !rst && (state == ST_DONE);
    busy    = !rst && (state != ST_IDLE);
  end

  // Transfer strobes and column/row position decodes.
  always_comb begin
    s_fire       = s_valid && s_ready;
    m_fire       = m_valid && m_ready;
    in_last_col  = (col == CW'(IMG_W - 1));
    out_last_col = (col == CW'(2 * IMG_W - 1));
    row_last     = (row == RW'(IMG_H - 2));
    odd_row      = is_odd_row_state(state);
    wr_idx       = col[XW-1:0];
    // Bottom row moves up between row pairs, and also once more for the final
    // pair where the missing row r+1 clamps onto the last input row.
    copy_down    = (state == ST_SHIFT) ||
                   ((state == ST_EMIT_ODD) && m_fire && out_last_col && row_last);
  end

  // Frame sequencer: loads two rows, emits their four output rows, slides down a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      col    <= '0;
      row    <= '0;
      mode_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_fire) begin
            mode_q <= mode;
            col    <= CW'(1);
            state  <= ST_LOAD_TOP;
          end
        end
        ST_LOAD_TOP: begin
          if (s_fire) begin
            if (in_last_col) begin
              col   <= '0;
              state <= ST_LOAD_BOT;
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        ST_LOAD_BOT: begin
          if (s_fire) begin
            if (in_last_col) begin
              col   <= '0;
              state <= ST_EMIT_EVEN;
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        ST_EMIT_EVEN, ST_LAST_EVEN: begin
          if (m_fire) begin
            if (out_last_col) begin
              col   <= '0;
              state <= (state == ST_EMIT_EVEN) ? ST_EMIT_ODD : ST_LAST_ODD;
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        ST_EMIT_ODD: begin
          if (m_fire) begin
            if (out_last_col) begin
              col   <= '0;
              state <= row_last ? ST_LAST_EVEN : ST_SHIFT;
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        ST_SHIFT: begin
          row   <= row + RW'(1);
          state <= ST_LOAD_BOT;
        end
        ST_LAST_ODD: begin
          if (m_fire) begin
            if (out_last_col) begin
              col   <= '0;
              state <= ST_DONE;
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        ST_DONE: begin
          row   <= '0;
          state <= ST_IDLE;
        end
        default: begin
          col   <= '0;
          row   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Line buffers: capture input pixels and slide BOT into TOP; contents need no reset.
  always_ff @(posedge clk) begin
    if (s_fire && (state != ST_LOAD_BOT)) begin
      top_buf[wr_idx] <= s_data;
    end
    if (s_fire && (state == ST_LOAD_BOT)) begin
      bot_buf[wr_idx] <= s_data;
    end
    if (copy_down) begin
      for (int i = 0; i < IMG_W; i++) begin
        top_buf[i] <= bot_buf[i];
      end
    end
  end

  // Tap fetch: output column 2c+b reads input columns c and c+1, clamped at the right edge.
  always_comb begin
    tap_c  = col[CW-1:1];
    tap_cn = (tap_c == XW'(IMG_W - 1)) ? tap_c : tap_c + XW'(1);
    t0     = top_buf[tap_c];
    t1     = top_buf[tap_cn];
    b0     = bot_buf[tap_c];
    b1     = bot_buf[tap_cn];
  end

  // FRAC only tags the binary point; a point outside the sample word is a bad
  // configuration, so no datapath is built for it.
  if (FRAC <= LENGTH) begin : g_lanes
    for (genvar k = 0; k < CH; k++) begin : g_ch
      upsample_interp2x #(
        .LENGTH (LENGTH)
      ) u_interp (
        .p00     (t0[k*LENGTH +: LENGTH]),
        .p01     (t1[k*LENGTH +: LENGTH]),
        .p10     (b0[k*LENGTH +: LENGTH]),
        .p11     (b1[k*LENGTH +: LENGTH]),
        .a       (odd_row),
        .b       (col[0]),
        .nearest (mode_q),
        .q       (m_data[k*LENGTH +: LENGTH])
      );
    end
  end else begin : g_no_lanes
    assign m_data = '0;
  end

endmodule

// File: tb/tb_upsample2x_stream.sv
// Bench for upsample2x_stream: a 4x4 CH=1 instance and a 6x3 CH=3 instance.
// Expected pixels come from a direct formula over the input frame.
// Handshakes are driven and sampled on the falling clock edge.
module tb_upsample2x_stream;
  typedef logic [35:0] beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst;
  logic [1:0]       mode;
  logic [1:0]       s_valid;
  logic [1:0]       m_ready;
  logic [1:0][35:0] s_data;
  wire  [1:0]       s_ready, m_valid, m_eol, m_last, done, busy;
  wire  [11:0]      a_m_data;
  wire  [35:0]      b_m_data;

  upsample2x_stream #(.IMG_W(4), .IMG_H(4), .LENGTH(12), .FRAC(8), .CH(1)) u_dut_a (
    .clk(clk), .rst(rst[0]), .mode(mode[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .s_data(s_data[0][11:0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(a_m_data),
    .m_eol(m_eol[0]), .m_last(m_last[0]), .done(done[0]), .busy(busy[0]));

  upsample2x_stream #(.IMG_W(6), .IMG_H(3), .LENGTH(12), .FRAC(8), .CH(3)) u_dut_b (
    .clk(clk), .rst(rst[1]), .mode(mode[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .s_data(s_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(b_m_data),
    .m_eol(m_eol[1]), .m_last(m_last[1]), .done(done[1]), .busy(busy[1]));

  int cyc_now = 0;
  always @(posedge clk) cyc_now <= cyc_now + 1;

  beat_t got_dat[$];
  bit    got_eol[$];
  bit    got_last[$];
  int    got_cyc[$];
  int    stall_bad, first_valid_cyc, last_load_cyc;
  bit    send_to, coll_to;
  logic  done1, done2, busy2;
  int    n_checks = 0;
  int    n_fail = 0;

  function automatic int w_of(input bit sel);  return sel ? 6 : 4; endfunction
  function automatic int h_of(input bit sel);  return sel ? 3 : 4; endfunction
  function automatic int ch_of(input bit sel); return sel ? 3 : 1; endfunction
  function automatic beat_t mdata(input bit sel);
    return sel ? b_m_data : {24'd0, a_m_data};
  endfunction

  // Output pixel (y,x) straight from the upsampling rules.
  function automatic beat_t ref_beat(input beat_t f[$], input int w, input int h, input int ch,
                                     input int nearest, input int y, input int x);
    int r = y / 2;
    int a = y % 2;
    int c = x / 2;
    int b = x % 2;
    int c1 = (c + 1 > w - 1) ? w - 1 : c + 1;
    int r1 = (r + 1 > h - 1) ? h - 1 : r + 1;
    beat_t q00 = f[r*w + c];
    beat_t q01 = f[r*w + c1];
    beat_t q10 = f[r1*w + c];
    beat_t q11 = f[r1*w + c1];
    beat_t res = '0;
    for (int k = 0; k < ch; k++) begin
      int v00 = int'(q00[k*12 +: 12]);
      int v01 = int'(q01[k*12 +: 12]);
      int v10 = int'(q10[k*12 +: 12]);
      int v11 = int'(q11[k*12 +: 12]);
      int v;
      if (nearest != 0 || (a == 0 && b == 0)) v = v00;
      else if (a == 0) v = (v00 + v01 + 1) / 2;
      else if (b == 0) v = (v00 + v10 + 1) / 2;
      else v = (v00 + v01 + v10 + v11 + 2) / 4;
      res[k*12 +: 12] = v[11:0];
    end
    return res;
  endfunction

  // Number of collected pixels that differ from the formula (size mismatch counts once).
  function automatic int frame_errs(input bit sel, input beat_t f[$], input int nearest);
    int w2 = 2 * w_of(sel);
    int n = w2 * 2 * h_of(sel);
    int e = 0;
    if (got_dat.size() != n) e++;
    for (int j = 0; j < n && j < got_dat.size(); j++)
      if (got_dat[j] !== ref_beat(f, w_of(sel), h_of(sel), ch_of(sel), nearest, j / w2, j % w2)) e++;
    return e;
  endfunction

  // Number of beats whose eol/last flags are misplaced.
  function automatic int flag_errs(input bit sel);
    int w2 = 2 * w_of(sel);
    int n = w2 * 2 * h_of(sel);
    int e = (got_eol.size() != n) ? 1 : 0;
    for (int j = 0; j < got_eol.size(); j++) begin
      if (got_eol[j] != ((j % w2) == w2 - 1)) e++;
      if (got_last[j] != (j == n - 1)) e++;
    end
    return e;
  endfunction

  task automatic send(input bit sel, input beat_t f[$], input int gap, input bit toggle);
    int i = 0;
    int cyc = 0;
    bit flipped = 0;
    while (i < f.size() && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (toggle && i == 1 && !flipped) begin
        mode[sel] = ~mode[sel];
        flipped = 1;
      end
      if (gap > 0 && int'($urandom_range(99)) < gap) s_valid[sel] = 1'b0;
      else begin
        s_valid[sel] = 1'b1;
        s_data[sel] = f[i];
      end
      if (s_valid[sel] && s_ready[sel]) begin
        if (i == 2 * w_of(sel) - 1) last_load_cyc = cyc_now;
        i++;
      end
    end
    if (i < f.size()) send_to = 1'b1;
    @(negedge clk);
    s_valid[sel] = 1'b0;
  endtask

  task automatic collect(input bit sel, input int n, input int rdy);
    int cyc = 0;
    bit stalled = 0;
    logic [37:0] held = '0;
    logic [37:0] now_v;
    got_dat.delete(); got_eol.delete(); got_last.delete(); got_cyc.delete();
    stall_bad = 0;
    first_valid_cyc = -1;
    coll_to = 0;
    while (got_dat.size() < n && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      now_v = {mdata(sel), m_eol[sel], m_last[sel]};
      if (stalled && (!m_valid[sel] || now_v !== held)) stall_bad++;
      m_ready[sel] = (int'($urandom_range(99)) < rdy);
      stalled = m_valid[sel] && !m_ready[sel];
      held = now_v;
      if (m_valid[sel] && first_valid_cyc < 0) first_valid_cyc = cyc_now;
      if (m_valid[sel] && m_ready[sel]) begin
        got_dat.push_back(mdata(sel));
        got_eol.push_back(m_eol[sel]);
        got_last.push_back(m_last[sel]);
        got_cyc.push_back(cyc_now);
      end
    end
    if (got_dat.size() < n) coll_to = 1'b1;
    @(negedge clk);
    m_ready[sel] = 1'b0;
    done1 = done[sel];
    @(negedge clk);
    done2 = done[sel];
    busy2 = busy[sel];
  endtask

  task automatic run_frame(input bit sel, input beat_t f[$], input int gap, input int rdy,
                           input bit toggle);
    send_to = 1'b0;
    fork
      send(sel, f, gap, toggle);
      collect(sel, 4 * f.size(), rdy);
    join
  endtask

  task automatic test_reset();
    rst = 2'b11; mode = 2'b00; s_valid = 2'b00; m_ready = 2'b00; s_data = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({s_ready, m_valid, m_eol, m_last, done, busy} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0", {s_ready, m_valid, m_eol, m_last, done, busy});
    end
    rst = 2'b00;
    @(negedge clk);
    n_checks++;
    if (s_ready !== 2'b11) begin
      n_fail++; $display("FAIL ready_after_reset: got %b expected 11", s_ready);
    end
    n_checks++;
    if ({m_valid, busy, done} !== 6'd0) begin
      n_fail++; $display("FAIL idle_after_reset: got %b expected 0", {m_valid, busy, done});
    end
  endtask

  task automatic test_bilinear();
    beat_t f[$];
    int e, gaps;
    int exp_v[6] = '{35, 40, 55, 60, 65, 185};
    int idx[6]   = '{0, 1, 8, 9, 7, 63};
    for (int i = 0; i < 16; i++) f.push_back(beat_t'(35 + 10 * i));
    mode[0] = 1'b0;
    run_frame(0, f, 0, 100, 0);
    n_checks++;
    if (send_to || coll_to) begin n_fail++; $display("FAIL bil_timeout: got %0d beats expected 64", got_dat.size()); end
    for (int j = 0; j < 6; j++) begin
      n_checks++;
      if (got_dat[idx[j]] !== beat_t'(exp_v[j])) begin
        n_fail++; $display("FAIL bil_beat%0d: got %0d expected %0d", idx[j], got_dat[idx[j]], exp_v[j]);
      end
    end
    n_checks++;
    if (first_valid_cyc !== last_load_cyc + 1) begin
      n_fail++; $display("FAIL bil_latency: got cycle %0d expected %0d", first_valid_cyc, last_load_cyc + 1);
    end
    e = frame_errs(0, f, 0);
    n_checks++;
    if (e !== 0) begin n_fail++; $display("FAIL bil_frame: got %0d bad beats expected 0", e); end
    e = flag_errs(0);
    n_checks++;
    if (e !== 0) begin n_fail++; $display("FAIL bil_flags: got %0d bad flags expected 0", e); end
    gaps = 0;
    for (int j = 0; j + 1 < got_cyc.size(); j++)
      if ((j / 16) == ((j + 1) / 16) && got_cyc[j+1] - got_cyc[j] != 1) gaps++;
    n_checks++;
    if (gaps !== 0) begin n_fail++; $display("FAIL bil_bubbles: got %0d gaps expected 0", gaps); end
    n_checks++;
    if ({done1, done2, busy2} !== 3'b100) begin
      n_fail++; $display("FAIL bil_done: got done,done,busy=%b expected 100", {done1, done2, busy2});
    end
  endtask

  task automatic test_nearest();
    beat_t f[$];
    int e;
    int row0[8] = '{35, 35, 45, 45, 55, 55, 65, 65};
    for (int i = 0; i < 16; i++) f.push_back(beat_t'(35 + 10 * i));
    mode[0] = 1'b1;
    run_frame(0, f, 0, 100, 0);
    e = 0;
    for (int j = 0; j < 8; j++) if (got_dat[j] !== beat_t'(row0[j])) e++;
    n_checks++;
    if (e !== 0) begin n_fail++; $display("FAIL nn_row0: got %0d bad beats expected 0", e); end
    e = frame_errs(0, f, 1);
    n_checks++;
    if (e !== 0) begin n_fail++; $display("FAIL nn_frame: got %0d bad beats expected 0", e); end
    n_checks++;
    if (got_last[63] !== 1'b1 || done1 !== 1'b1) begin
      n_fail++; $display("FAIL nn_last: got last=%b done=%b expected 1 1", got_last[63], done1);
    end
  endtask

  task automatic test_rounding();
    beat_t f[$];
    int e;
    f.push_back(beat_t'(0));
    f.push_back(beat_t'(1));
    for (int i = 2; i < 16; i++) f.push_back(beat_t'($urandom_range(4095)));
    mode[0] = 1'b0;
    run_frame(0, f, 20, 70, 0);
    n_checks++;
    if (got_dat[1] !== beat_t'(1)) begin n_fail++; $display("FAIL rnd_half: got %0d expected 1", got_dat[1]); end
    e = frame_errs(0, f, 0);
    n_checks++;
    if (e !== 0) begin n_fail++; $display("FAIL rnd_frame: got %0d bad beats expected 0", e); end
    f.delete();
    for (int i = 0; i < 16; i++) f.push_back(beat_t'(4095));
    run_frame(0, f, 0, 100, 0);
    e = (got_dat.size() != 64) ? 1 : 0;
    foreach (got_dat[j]) if (got_dat[j] !== beat_t'(4095)) e++;
    n_checks++;
    if (e !== 0) begin n_fail++; $display("FAIL rnd_saturated: got %0d bad beats expected 0", e); end
  endtask

  task automatic test_random_stall();
    beat_t f[$];
    int e;
    for (int it = 0; it < 3; it++) begin
      f.delete();
      for (int i = 0; i < 18; i++) f.push_back(beat_t'({$urandom(), $urandom()}));
      mode[1] = (it == 1);
      run_frame(1, f, 30, 50, 0);
      e = frame_errs(1, f, (it == 1) ? 1 : 0);
      n_checks++;
      if (e !== 0) begin n_fail++; $display("FAIL rs_frame%0d: got %0d bad beats expected 0", it, e); end
      e = flag_errs(1);
      n_checks++;
      if (e !== 0) begin n_fail++; $display("FAIL rs_flags%0d: got %0d bad flags expected 0", it, e); end
      n_checks++;
      if (stall_bad !== 0) begin n_fail++; $display("FAIL rs_stall%0d: got %0d unstable beats expected 0", it, stall_bad); end
      n_checks++;
      if (done1 !== 1'b1 || send_to || coll_to) begin
        n_fail++; $display("FAIL rs_done%0d: got done=%b timeout=%b expected 1 0", it, done1, send_to | coll_to);
      end
    end
  endtask

  task automatic test_reset_midframe();
    beat_t f[$];
    beat_t g[$];
    int e;
    for (int i = 0; i < 10; i++) g.push_back(beat_t'($urandom_range(4095)));
    mode[0] = 1'b0;
    m_ready[0] = 1'b1;
    send(0, g, 0, 0);
    rst[0] = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy[0], m_valid[0], s_ready[0]} !== 3'b000) begin
      n_fail++; $display("FAIL rm_in_reset: got busy,valid,ready=%b expected 000", {busy[0], m_valid[0], s_ready[0]});
    end
    rst[0] = 1'b0;
    m_ready[0] = 1'b0;
    for (int i = 0; i < 16; i++) f.push_back(beat_t'(35 + 10 * i));
    run_frame(0, f, 0, 100, 0);
    e = frame_errs(0, f, 0);
    n_checks++;
    if (e !== 0) begin n_fail++; $display("FAIL rm_frame: got %0d bad beats expected 0", e); end
    n_checks++;
    if (got_dat[63] !== beat_t'(185)) begin n_fail++; $display("FAIL rm_corner: got %0d expected 185", got_dat[63]); end
  endtask

  task automatic test_mode_toggle();
    beat_t f[$];
    int e;
    for (int i = 0; i < 16; i++) f.push_back(beat_t'($urandom_range(4095)));
    mode[0] = 1'b1;
    run_frame(0, f, 10, 80, 1);
    e = frame_errs(0, f, 1);
    n_checks++;
    if (e !== 0) begin n_fail++; $display("FAIL mt_nearest: got %0d bad beats expected 0", e); end
    run_frame(0, f, 10, 80, 1);
    e = frame_errs(0, f, 0);
    n_checks++;
    if (e !== 0) begin n_fail++; $display("FAIL mt_bilinear: got %0d bad beats expected 0", e); end
  endtask

  initial begin
    test_reset();
    test_bilinear();
    test_nearest();
    test_rounding();
    test_random_stall();
    test_reset_midframe();
    test_mode_toggle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
